// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array sequencer and its output FIFO.
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ACC_WIDTH  = 32;
    localparam int DEFAULT_ARRAY_SIZE = 8;
    localparam int DEFAULT_PIPE_LAT   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        CAPTURE,
        DRAIN
    } seq_state_t;

    typedef logic [DEFAULT_ARRAY_SIZE-1:0][DEFAULT_DATA_WIDTH-1:0] operand_row_t;
    typedef logic [DEFAULT_ARRAY_SIZE-1:0][DEFAULT_ACC_WIDTH-1:0]  result_row_t;

endpackage

// File: rtl/seq_out_fifo.sv
// Two-entry result-row FIFO; the head entry is read straight from registers.
module seq_out_fifo #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Load/compute/capture/drain controller for one weight-stationary systolic array tile.
// Optional SEQ_PERF_CNT_EN adds a saturating per-tile cycle_count output.
module systolic_array_sequencer
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int PIPE_LAT   = DEFAULT_PIPE_LAT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_a,
    input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] in_b,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  out_c,
    output logic                                  arr_enable,
    output logic                                  arr_input_write,
    output logic                                  arr_output_write,
    output logic                                  arr_output_read,
    output logic [$clog2(ARRAY_SIZE)-1:0]         arr_row_ptr,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] arr_a_in,
    output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] arr_b_in,
    input  logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  arr_c_out
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                           cycle_count
`endif
);

    localparam int PTR_W = $clog2(ARRAY_SIZE);
    localparam int CNT_W = $clog2((PIPE_LAT > ARRAY_SIZE) ? PIPE_LAT : ARRAY_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(ARRAY_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] ROWS      = CNT_W'(ARRAY_SIZE);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] pop_cnt_next;
    logic             rd_pending;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [1:0]       fifo_occ;
    logic [2:0]       slots_used;

    assign arr_a_in   = in_a;
    assign arr_b_in   = in_b;
    assign busy       = (state != IDLE);
    assign arr_enable = busy;
    assign out_valid  = !fifo_empty;
    assign fifo_pop   = out_valid && out_ready;
    assign fifo_occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    // A read in flight already owns a FIFO slot; a pop this cycle frees one.
    assign slots_used = {1'b0, fifo_occ} + {2'b00, rd_pending} - {2'b00, fifo_pop};

    seq_out_fifo #(
        .WIDTH(ARRAY_SIZE * ACC_WIDTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pending),
        .push_data(arr_c_out),
        .pop      (fifo_pop),
        .head     (out_c),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pop_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pop_cnt    <= pop_cnt_next;
            rd_pending <= arr_output_read;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        pop_cnt_next     = pop_cnt;
        in_ready         = 1'b0;
        done             = 1'b0;
        arr_input_write  = 1'b0;
        arr_output_write = 1'b0;
        arr_output_read  = 1'b0;
        arr_row_ptr      = cnt[PTR_W-1:0];
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = LOAD;
                    cnt_next     = '0;
                    pop_cnt_next = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    arr_input_write = 1'b1;
                    if (cnt == LAST_ROW) begin
                        cnt_next   = '0;
                        state_next = COMPUTE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (cnt == LAST_WAIT) begin
                    cnt_next   = '0;
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                arr_output_write = 1'b1;
                if (cnt == LAST_ROW) begin
                    cnt_next   = '0;
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DRAIN: begin
                // cnt counts reads issued, pop_cnt counts rows handed to the host.
                if (cnt != ROWS && slots_used < 3'd2) begin
                    arr_output_read = 1'b1;
                    cnt_next        = cnt + 1'b1;
                end
                if (fifo_pop) begin
                    pop_cnt_next = pop_cnt + 1'b1;
                    if (pop_cnt == LAST_ROW) begin
                        done         = 1'b1;
                        state_next   = IDLE;
                        cnt_next     = '0;
                        pop_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    // The start cycle itself is counted, so a finished tile reads its start-to-done latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                cycle_count <= 32'd1;
            end
        end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    // No performance counter in this build.
`endif

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench for systolic_array_sequencer with a behavioural array model on the arr_* side.
`timescale 1ns/1ps
module tb_systolic_array_sequencer;
    import systolic_pkg::*;

    localparam int N  = DEFAULT_ARRAY_SIZE;
    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int AW = DEFAULT_ACC_WIDTH;
    localparam int MIN_LAT = 43;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    operand_row_t in_a = '0;
    operand_row_t in_b = '0;
    operand_row_t arr_a_in, arr_b_in;
    result_row_t  out_c;
    result_row_t  arr_c_out = '0;
    logic busy, done, in_ready, out_valid;
    logic arr_enable, arr_input_write, arr_output_write, arr_output_read;
    logic [$clog2(N)-1:0] arr_row_ptr;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rows_seen = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int reads_seen = 0;
    int wr_idx = 0;
    int rd_row = 0;
    bit rd_seen = 1'b0;
    result_row_t  exp_q[$];
    operand_row_t mdl_a[N];
    operand_row_t mdl_b[N];

    systolic_array_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_c           (out_c),
        .arr_enable      (arr_enable),
        .arr_input_write (arr_input_write),
        .arr_output_write(arr_output_write),
        .arr_output_read (arr_output_read),
        .arr_row_ptr     (arr_row_ptr),
        .arr_a_in        (arr_a_in),
        .arr_b_in        (arr_b_in),
        .arr_c_out       (arr_c_out)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_count     (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [N*AW-1:0] actual,
                               input logic [N*AW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Hand-derived tile patterns: 0 = ramp x identity, 1 = signed skew x 2I, 2 = negative ramp x anti-identity.
    function automatic operand_row_t a_row(int pat, int r);
        operand_row_t row;
        for (int j = 0; j < N; j++) begin
            case (pat)
                0:       row[j] = DW'(r * 8 + j + 1);
                1:       row[j] = DW'(3 * (r - j));
                default: row[j] = DW'(-(r * 8 + j + 1));
            endcase
        end
        return row;
    endfunction

    function automatic operand_row_t b_row(int pat, int r);
        operand_row_t row;
        for (int j = 0; j < N; j++) begin
            case (pat)
                0:       row[j] = (j == r) ? DW'(1) : DW'(0);
                1:       row[j] = (j == r) ? DW'(2) : DW'(0);
                default: row[j] = (j == N - 1 - r) ? DW'(1) : DW'(0);
            endcase
        end
        return row;
    endfunction

    function automatic result_row_t exp_row(int pat, int r);
        result_row_t row;
        for (int j = 0; j < N; j++) begin
            case (pat)
                0:       row[j] = AW'(r * 8 + j + 1);
                1:       row[j] = AW'(6 * (r - j));
                default: row[j] = AW'(-(r * 8 + N - j));
            endcase
        end
        return row;
    endfunction

    function automatic result_row_t model_row(int r);
        result_row_t row;
        logic signed [DW-1:0] av, bv;
        int sum;
        for (int j = 0; j < N; j++) begin
            sum = 0;
            for (int k = 0; k < N; k++) begin
                av = mdl_a[r][k];
                bv = mdl_b[k][j];
                sum += av * bv;
            end
            row[j] = AW'(sum);
        end
        return row;
    endfunction

    // Array model: captures written rows, answers reads one cycle later, poisons idle cycles.
    always @(negedge clk) begin
        if (!rst) begin
            wr_idx = 0;
            rd_seen = 1'b0;
        end else begin
            if (!busy && start) wr_idx = 0;
            if (in_valid || arr_input_write)
                checkOutput("input_write_gate", arr_input_write, in_valid && in_ready);
            if (arr_input_write) begin
                checkOutput($sformatf("write_row_ptr%0d", wr_idx), arr_row_ptr, wr_idx);
                if (wr_idx < N) begin
                    mdl_a[wr_idx] = arr_a_in;
                    mdl_b[wr_idx] = arr_b_in;
                end
                wr_idx++;
            end
            if (arr_output_read) begin
                rd_seen = 1'b1;
                rd_row = int'(arr_row_ptr);
                reads_seen++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_seen) arr_c_out = model_row(rd_row);
        else arr_c_out = {N{32'hDEAD_BEEF}};
        rd_seen = 1'b0;
    end

    // Monitor: pops the scoreboard on every accepted result row.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_row: actual %0h required none", out_c);
                end else begin
                    checkOutput($sformatf("result_row%0d", rows_seen), out_c, exp_q.pop_front());
                end
                rows_seen++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checkOutput("done_with_last_row", {out_valid && out_ready, exp_q.size() == 0}, 2'b11);
            end
        end
    end

    task automatic applyStimulus(input int pat, input bit toggle);
        int tries;
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        for (int r = 0; r < N; r++) exp_q.push_back(exp_row(pat, r));
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < N; r++) begin
            in_valid = 1'b1;
            in_a = a_row(pat, r);
            in_b = b_row(pat, r);
            #1;
            tries = 0;
            while (!in_ready && tries < 20) begin
                @(negedge clk);
                #1;
                tries++;
            end
            if (tries == 20) checkOutput("load_in_ready_timeout", in_ready, 1'b1);
            @(negedge clk);
            if (toggle) begin
                in_valid = 1'b0;
                in_a = '1;
                in_b = '1;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input string name, input int prev_done, input bit check_lat);
        int t = 0;
        while (done_cnt == prev_done && t < 400) begin
            @(negedge clk);
            #2;
            t++;
        end
        checkOutput({name, "_done_count"}, done_cnt, prev_done + 1);
        if (check_lat) checkOutput({name, "_latency"}, done_cyc - start_cyc + 1, MIN_LAT);
        checkOutput({name, "_write_count"}, wr_idx, N);
        @(negedge clk);
        #1;
        checkOutput({name, "_idle_after_done"}, {busy, done, out_valid}, 3'b000);
`ifdef SEQ_PERF_CNT_EN
        if (check_lat) begin
            checkOutput({name, "_cycle_count"}, cycle_count, MIN_LAT);
            repeat (3) @(negedge clk);
            checkOutput({name, "_cycle_count_hold"}, cycle_count, MIN_LAT);
        end
`endif
    endtask

    initial begin
        int base, r2, prev, t;
        #2 rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b0);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_arr_ctrl", {arr_enable, arr_input_write, arr_output_write, arr_output_read, arr_row_ptr}, '0);
        checkOutput("reset_out_c", out_c, '0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] tile 1: identity weights, no stalls");
        prev = done_cnt;
        applyStimulus(0, 1'b0);
        waitDone("tile1", prev, 1'b1);

        $display("[TB] tile 2: toggled in_valid, start during compute, output stall");
        prev = done_cnt;
        base = rows_seen;
        applyStimulus(1, 1'b1);
        start = 1'b1;
        in_valid = 1'b1;
        in_a = '1;
        #1;
        checkOutput("compute_in_ready", in_ready, 1'b0);
        checkOutput("compute_busy", busy, 1'b1);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        t = 0;
        while (rows_seen < base + 3 && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        checkOutput("tile2_rows_before_stall", rows_seen >= base + 3, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        r2 = reads_seen;
        repeat (8) @(negedge clk);
        #2;
        checkOutput("stall_reads_stopped", reads_seen - r2, 0);
        checkOutput("stall_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDone("tile2", prev, 1'b0);
        checkOutput("tile2_rows_delivered", rows_seen - base, N);

        $display("[TB] tile 3: reset during drain");
        prev = done_cnt;
        base = rows_seen;
        applyStimulus(2, 1'b0);
        t = 0;
        while (rows_seen < base + 1 && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        checkOutput("tile3_reached_drain", rows_seen >= base + 1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_arr_ctrl", {arr_enable, arr_input_write, arr_output_write, arr_output_read, arr_row_ptr}, '0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        checkOutput("midrst_no_done", done_cnt, prev);

        $display("[TB] tile 4: full tile after reset");
        prev = done_cnt;
        applyStimulus(2, 1'b0);
        waitDone("tile4", prev, 1'b1);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/systolic_array_sequencer.md
# systolic_array_sequencer

Controller that drives the 8x8 weight-stationary systolic array core from the system side. It accepts paired activation/weight rows over a valid/ready stream and issues row-indexed writes. It then sequences the compute, capture and read phases of the array's output de-skew buffer, and returns result rows over a second valid/ready stream. One instance sits between the host/DMA interface and each array tile.

## Interface
Parameters:
- DATA_WIDTH, 8, signed operand width
- ACC_WIDTH, 32, signed accumulator/result width
- ARRAY_SIZE, 8, rows/columns of the array; row pointer width is $clog2(ARRAY_SIZE)
- PIPE_LAT, 16, cycles from the last input write to the first valid output-capture cycle

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin one tile operation; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last result row is accepted
- in_valid / in_ready  in / out  1 / 1  input row handshake
- in_a  in  ARRAY_SIZE x DATA_WIDTH  activation row
- in_b  in  ARRAY_SIZE x DATA_WIDTH  weight row
- out_valid / out_ready  out / in  1 / 1  result row handshake
- out_c  out  ARRAY_SIZE x ACC_WIDTH  result row
- arr_enable, arr_input_write, arr_output_write, arr_output_read  out  1 each  array controls
- arr_row_ptr  out  $clog2(ARRAY_SIZE)  array row pointer
- arr_a_in, arr_b_in  out  ARRAY_SIZE x DATA_WIDTH  array operands; combinational pass-through of in_a/in_b
- arr_c_out  in  ARRAY_SIZE x ACC_WIDTH  array result row, valid 1 cycle after arr_output_read
- cycle_count  out  32  only with SEQ_PERF_CNT_EN

## Operation
- FSM states: IDLE, LOAD, COMPUTE, CAPTURE, DRAIN.
- IDLE -> LOAD on start.
- LOAD:
  - in_ready=1.
  - Each beat (in_valid&&in_ready) drives arr_input_write=1 with arr_row_ptr=row counter, then increments the counter.
  - After beat ARRAY_SIZE-1 -> COMPUTE, counter cleared.
- COMPUTE: wait counter counts 0..PIPE_LAT-1, then -> CAPTURE.
- CAPTURE: arr_output_write=1 for exactly ARRAY_SIZE consecutive cycles, then -> DRAIN.
- DRAIN:
  - arr_output_read is issued only when the 2-entry output FIFO has a free slot, counting outstanding reads.
  - Returning arr_c_out is pushed into the FIFO 1 cycle later.
  - After ARRAY_SIZE reads are issued and the FIFO has been popped ARRAY_SIZE times: done=1 for one cycle, -> IDLE.
- arr_enable=1 in every state except IDLE.
- No arithmetic. Results are passed bit-exact at ACC_WIDTH; no truncation or sign handling.
- start while busy: ignored.
- in_valid outside LOAD: in_ready=0, no write.
- out_ready low: FIFO fills, reads stop, and no result is lost or duplicated.
- Reset at any time: immediate return to IDLE. Counters, FIFO and all outputs go to 0; in_ready=0, out_valid=0.

## Timing
- arr_input_write is combinational from the handshake, in the same cycle as the accepted beat.
- COMPUTE lasts exactly PIPE_LAT cycles.
- CAPTURE lasts exactly ARRAY_SIZE cycles.
- Best case: first out_valid at 2 cycles after DRAIN entry, then one row per cycle with out_ready held high.
- Minimum tile latency, start to done with no stalls: 1 + ARRAY_SIZE + PIPE_LAT + ARRAY_SIZE + ARRAY_SIZE + 2 cycles.
- done and the last out handshake occur in the same cycle. Next start is accepted the following cycle.
- out_c/out_valid are driven from FIFO head registers; no combinational path from out_ready to out_valid.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - cycle_count port exists.
  - Cleared on start, increments each busy cycle, holds its value in IDLE, saturates at all-ones.
- Not defined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package systolic_pkg: state enum seq_state_t, ARRAY_SIZE default, and row type aliases for operand and result rows.
- One sub-module, seq_out_fifo: 2-entry, ACC_WIDTH x ARRAY_SIZE wide, with full/empty flags and the same clock/reset.

## Test plan
- Reset mid-DRAIN (rst=0 for 1 cycle) -> busy=0, out_valid=0, arr_* controls 0; a new tile then completes normally.
- Identity B, A rows 1..8 with out_ready held 1 -> out_c rows equal the A matrix; done in exactly 3*8+16+3=43 cycles after start.
- in_valid toggled 1/0 every cycle during LOAD -> arr_row_ptr 0..7 appears only on accepted beats; exactly 8 arr_input_write pulses.
- out_ready low for 10 cycles mid-DRAIN -> arr_output_read stops after FIFO full; all 8 rows delivered in order, none duplicated.
- start pulsed during COMPUTE -> ignored; in_valid during COMPUTE -> in_ready=0.
- With SEQ_PERF_CNT_EN, no stalls -> cycle_count=43 after done and holds in IDLE.
